// File: rtl/hex_seq_pkg.sv
// Shared state encoding and seven-segment constants for the hex display sequencer.
package hex_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the glyph for nibble 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble-to-segment decoder with a blank override.
module hex_seg_decoder
    import hex_seq_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : seg_lookup(nibble_i);

endmodule

// File: rtl/hex_display_sequencer.sv
// Avalon-MM master writing one segment pattern per digit to a row of HEX PIOs.
// Optional leading-zero blanking: define HEX_SEQ_LEADING_ZERO_BLANK_EN.
module hex_display_sequencer
    import hex_seq_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] STRIDE     = 32'h10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic                    done,
    output logic [31:0]             avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest
);

    localparam int unsigned     IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [1:0]                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]      blank_vec;
    logic [6:0]                 seg;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        value_d = value_q;
        case (state_q)
            ST_IDLE: begin
                if (value_valid) begin
                    value_d = value;
                    idx_d   = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            value_q <= value_d;
        end
    end

`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
    // zero_above[i] is set when nibbles i..NUM_DIGITS-1 of the latched value are all zero.
    logic [NUM_DIGITS:1] zero_above;
    assign zero_above[NUM_DIGITS] = 1'b1;
    assign blank_vec[0] = 1'b0;
    for (genvar i = NUM_DIGITS - 1; i >= 1; i--) begin : g_blank
        assign zero_above[i] = zero_above[i+1] & (value_q[i] == 4'h0);
        assign blank_vec[i]  = zero_above[i];
    end
`else
    assign blank_vec = '0;
`endif

    hex_seg_decoder u_dec (
        .nibble_i (value_q[idx_q]),
        .blank_i  (blank_vec[idx_q]),
        .seg_o    (seg)
    );

    assign value_ready   = (state_q == ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign avm_write     = (state_q == ST_WRITE);
    assign avm_address   = avm_write ? (BASE_ADDR + 32'(idx_q) * STRIDE) : 32'h0;
    assign avm_writedata = avm_write ? {25'b0, seg} : 32'h0;

endmodule
